// File: rtl/env_int_gen_if.sv
// CPU-side bus bundle for env_int_gen: the Z80 strobes, address and write data.
// The tri-state read bus DI stays a plain port on the block itself.
`timescale 1ns/1ps
interface env_int_gen_if;
    logic       m1_n;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] addr;
    logic [7:0] DO;

    // CPU (or bench) side drives the bus.
    modport master (
        output m1_n, iorq_n, rd_n, wr_n, addr, DO
    );

    // Peripheral side only observes the bus.
    modport slave (
        input m1_n, iorq_n, rd_n, wr_n, addr, DO
    );
endinterface

// File: rtl/env_int_gen.sv
// env_int_gen: programmable interrupt source for the tv80s environment.
// A 16-bit down-counter raises int_n after TMO cycles and holds it until the
// CPU acknowledges (M1+IORQ), supplying the IM2 vector on DI. CTRL bit2 fires
// a fixed-length nmi_n pulse independent of the timer.
`timescale 1ns/1ps
module env_int_gen #(
    parameter logic [7:0]  BASE_ADDR = 8'h90,
    parameter int unsigned NMI_PULSE = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    env_int_gen_if.slave bus,
    output logic [7:0]   DI,
    output logic         int_n,
    output logic         nmi_n
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        PEND  = 2'd2
    } state_t;

    localparam logic [7:0] NMI_LOAD = 8'(NMI_PULSE);

    state_t      state_r, state_nx_s;
    logic [15:0] cnt_r, cnt_nx_s;
    logic [15:0] tmo_r;
    logic [7:0]  vec_r;
    logic        en_r, en_nx_s;
    logic        reload_r;
    logic        wsel_prev_r, ack_prev_r;
    logic        int_n_r, nmi_n_r;
    logic [7:0]  nmi_cnt_r;

    logic [7:0]  off_s;
    logic        hit_s, wsel_s, rsel_s, ack_s;
    logic        wr_evt_s, ack_evt_s, ctrl_wr_s;
    logic [7:0]  rdata_s, dout_s;
    logic        drive_s;

    // Offset arithmetic wraps, so any BASE_ADDR (aligned or not) decodes 4 bytes.
    assign off_s     = bus.addr - BASE_ADDR;
    assign hit_s     = (off_s < 8'd4);
    assign wsel_s    = !bus.iorq_n && !bus.wr_n && bus.m1_n && hit_s;
    assign rsel_s    = !bus.iorq_n && !bus.rd_n && bus.m1_n && hit_s;
    assign ack_s     = !bus.m1_n && !bus.iorq_n;
    // Multi-cycle Z80 strobes collapse to a single event on their first edge.
    assign wr_evt_s  = wsel_s && !wsel_prev_r;
    assign ack_evt_s = ack_s && !ack_prev_r;
    assign ctrl_wr_s = wr_evt_s && (off_s[1:0] == 2'd3);

    // Timer next-state logic; a disabling CTRL write overrides everything else.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        en_nx_s    = en_r;
        case (state_r)
            IDLE: begin
                if (ctrl_wr_s && bus.DO[0] && (tmo_r != 16'd0)) begin
                    cnt_nx_s   = tmo_r;
                    state_nx_s = COUNT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            COUNT: begin
                if (cnt_r <= 16'd1) begin
                    cnt_nx_s   = 16'd0;
                    state_nx_s = PEND;
                end else begin
                    cnt_nx_s   = cnt_r - 16'd1;
                end
            end
            PEND: begin
                if (ack_evt_s) begin
                    if (reload_r && (tmo_r != 16'd0)) begin
                        cnt_nx_s   = tmo_r;
                        state_nx_s = COUNT;
                    end else if (reload_r) begin
                        state_nx_s = IDLE;
                    end else begin
                        en_nx_s    = 1'b0;
                        state_nx_s = IDLE;
                    end
                end else begin
                    state_nx_s = PEND;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = 16'd0;
            end
        endcase
        if (ctrl_wr_s) begin
            en_nx_s = bus.DO[0];
            if (!bus.DO[0]) begin
                state_nx_s = IDLE;
            end else begin
                state_nx_s = state_nx_s;
            end
        end else begin
            en_nx_s = en_nx_s;
        end
    end

    // Timer state, counter, edge-detect history and registered int_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= 16'd0;
            en_r        <= 1'b0;
            wsel_prev_r <= 1'b0;
            ack_prev_r  <= 1'b0;
            int_n_r     <= 1'b1;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            en_r        <= en_nx_s;
            wsel_prev_r <= wsel_s;
            ack_prev_r  <= ack_s;
            int_n_r     <= (state_nx_s != PEND);
        end
    end

    // Programmable registers; TMO changes only take effect at the next load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_r    <= 16'd0;
            vec_r    <= 8'd0;
            reload_r <= 1'b0;
        end else if (wr_evt_s) begin
            case (off_s[1:0])
                2'd0:    tmo_r[7:0]  <= bus.DO;
                2'd1:    tmo_r[15:8] <= bus.DO;
                2'd2:    vec_r       <= bus.DO;
                2'd3:    reload_r    <= bus.DO[1];
                default: vec_r       <= vec_r;
            endcase
        end
    end

    // NMI pulse stretcher: a trigger (re)loads the counter, nmi_n low while nonzero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nmi_cnt_r <= 8'd0;
            nmi_n_r   <= 1'b1;
        end else begin
            nmi_n_r <= (nmi_cnt_r == 8'd0);
            if (ctrl_wr_s && bus.DO[2]) begin
                nmi_cnt_r <= NMI_LOAD;
            end else if (nmi_cnt_r != 8'd0) begin
                nmi_cnt_r <= nmi_cnt_r - 8'd1;
            end
        end
    end

    // Read-data mux and DI drive selection (register read or IM2 vector).
    always_comb begin
        rdata_s = 8'h00;
        case (off_s[1:0])
            2'd0:    rdata_s = tmo_r[7:0];
            2'd1:    rdata_s = tmo_r[15:8];
            2'd2:    rdata_s = vec_r;
            2'd3:    rdata_s = {(state_r == PEND), 4'b0000, 1'b0, reload_r, en_r};
            default: rdata_s = 8'h00;
        endcase
        if (rsel_s) begin
            drive_s = 1'b1;
            dout_s  = rdata_s;
        end else if (ack_s && (state_r == PEND)) begin
            drive_s = 1'b1;
            dout_s  = vec_r;
        end else begin
            drive_s = 1'b0;
            dout_s  = 8'h00;
        end
    end

    assign DI    = drive_s ? dout_s : 8'hzz;
    assign int_n = int_n_r;
    assign nmi_n = nmi_n_r;

endmodule

// File: tb/tb_env_int_gen.sv
// Self-checking bench for env_int_gen: expected interrupt cycles are queued
// when the enabling stimulus is driven and compared when int_n falls.
`timescale 1ns/1ps
module tb_env_int_gen;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    wire  [7:0] di;
    logic       int_n, nmi_n;

    env_int_gen_if bus();

    env_int_gen #(.BASE_ADDR(8'h90), .NMI_PULSE(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .DI      (di),
        .int_n   (int_n),
        .nmi_n   (nmi_n)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   nmi_lows = 0;
    int   nmi_fall_cyc = 0;
    logic nmi_prev = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    int   exp_q[$];
    logic [7:0] zval;

    // Edge counter: after posedge k (plus #1) cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    // NMI monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (nmi_n === 1'b0) begin
            nmi_lows <= nmi_lows + 1;
            if (nmi_prev === 1'b1) nmi_fall_cyc <= cyc;
        end
        nmi_prev <= nmi_n;
    end

    task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int hold,
                            output int wcyc, output logic int_at);
        @(negedge clk);
        bus.addr = a; bus.DO = d; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        @(posedge clk); #1;
        wcyc = cyc; int_at = int_n;
        for (int i = 1; i < hold; i++) @(posedge clk);
        @(negedge clk);
        bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.addr = a; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
        #1 d = di;
        #1 bus.iorq_n = 1'b1; bus.rd_n = 1'b1;
    endtask

    task automatic int_ack(output int acyc, output logic [7:0] d);
        @(negedge clk);
        bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
        #1 d = di;
        @(posedge clk); #1 acyc = cyc;
        @(posedge clk);
        @(negedge clk);
        bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
    endtask

    task automatic wait_int_low(input int budget, output int fcyc, output bit ok);
        ok = 1'b0; fcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (int_n === 1'b0) begin
                fcyc = cyc; ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        bus.m1_n = 1'b1; bus.iorq_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
        bus.addr = 8'h00; bus.DO = 8'h00;
        reset_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (int_n !== 1'b1) $display("FAIL reset_int_n got=%b exp=1", int_n); else n_pass++;
        n_checks++; if (nmi_n !== 1'b1) $display("FAIL reset_nmi_n got=%b exp=1", nmi_n); else n_pass++;
        n_checks++; if (di !== zval) $display("FAIL reset_di got=%h exp=%h", di, zval); else n_pass++;
        @(negedge clk) reset_n = 1'b1;
        io_read(8'h93, d);
        n_checks++; if (d !== 8'h00) $display("FAIL reset_ctrl got=%h exp=00", d); else n_pass++;
        io_read(8'h90, d);
        n_checks++; if (d !== 8'h00) $display("FAIL reset_tmo_lo got=%h exp=00", d); else n_pass++;
    endtask

    task automatic test_one_shot();
        int w, f, a, e; bit ok; logic ia; logic [7:0] d;
        io_write(8'h90, 8'h0A, 2, w, ia);
        io_write(8'h91, 8'h00, 2, w, ia);
        io_write(8'h92, 8'h40, 2, w, ia);
        io_read(8'h90, d);
        n_checks++; if (d !== 8'h0A) $display("FAIL rd_tmo_lo got=%h exp=0a", d); else n_pass++;
        io_read(8'h92, d);
        n_checks++; if (d !== 8'h40) $display("FAIL rd_vec got=%h exp=40", d); else n_pass++;
        io_write(8'h93, 8'h01, 2, w, ia);
        exp_q.push_back(w + 10);
        wait_int_low(40, f, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok) $display("FAIL oneshot_fall timeout exp_cyc=%0d", e);
        else if (f !== e) $display("FAIL oneshot_fall got_cyc=%0d exp_cyc=%0d", f, e);
        else n_pass++;
        io_read(8'h93, d);
        n_checks++; if (d !== 8'h81) $display("FAIL oneshot_ctrl_pend got=%h exp=81", d); else n_pass++;
        int_ack(a, d);
        n_checks++; if (d !== 8'h40) $display("FAIL oneshot_vec got=%h exp=40", d); else n_pass++;
        n_checks++; if (int_n !== 1'b1) $display("FAIL oneshot_int_clear got=%b exp=1", int_n); else n_pass++;
        io_read(8'h93, d);
        n_checks++; if (d !== 8'h00) $display("FAIL oneshot_ctrl_after got=%h exp=00", d); else n_pass++;
    endtask

    task automatic test_reload();
        int w, f, a, e; bit ok; logic ia; logic [7:0] d;
        io_write(8'h90, 8'h03, 2, w, ia);
        io_write(8'h91, 8'h00, 2, w, ia);
        io_write(8'h93, 8'h03, 2, w, ia);
        exp_q.push_back(w + 3);
        for (int p = 0; p < 4; p++) begin
            wait_int_low(20, f, ok);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok) $display("FAIL reload_fall%0d timeout exp_cyc=%0d", p, e);
            else if (f !== e) $display("FAIL reload_fall%0d got_cyc=%0d exp_cyc=%0d", p, f, e);
            else n_pass++;
            if (p < 3) begin
                @(posedge clk);
                int_ack(a, d);
                n_checks++; if (d !== 8'h40) $display("FAIL reload_vec%0d got=%h exp=40", p, d); else n_pass++;
                exp_q.push_back(a + 3);
            end
        end
        io_write(8'h93, 8'h00, 1, w, ia);
        n_checks++; if (ia !== 1'b1) $display("FAIL reload_disable got=%b exp=1", ia); else n_pass++;
    endtask

    task automatic test_disable_pending();
        int w, f, a, e; bit ok; logic ia; logic [7:0] d;
        io_write(8'h90, 8'h05, 2, w, ia);
        io_write(8'h93, 8'h01, 2, w, ia);
        exp_q.push_back(w + 5);
        wait_int_low(20, f, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok) $display("FAIL dis_fall timeout exp_cyc=%0d", e);
        else if (f !== e) $display("FAIL dis_fall got_cyc=%0d exp_cyc=%0d", f, e);
        else n_pass++;
        repeat (3) @(posedge clk);
        io_write(8'h93, 8'h00, 1, w, ia);
        n_checks++; if (ia !== 1'b1) $display("FAIL dis_int_at_edge got=%b exp=1", ia); else n_pass++;
        int_ack(a, d);
        n_checks++; if (d !== zval) $display("FAIL dis_ack_di got=%h exp=%h", d, zval); else n_pass++;
        io_read(8'h93, d);
        n_checks++; if (d !== 8'h00) $display("FAIL dis_ctrl got=%h exp=00", d); else n_pass++;
    endtask

    task automatic test_nmi();
        int w, w2, base; logic ia;
        base = nmi_lows;
        io_write(8'h93, 8'h04, 1, w, ia);
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        n_checks++; if (nmi_lows - base !== 4) $display("FAIL nmi_width got=%0d exp=4", nmi_lows - base); else n_pass++;
        n_checks++; if (nmi_fall_cyc !== w + 1) $display("FAIL nmi_start got_cyc=%0d exp_cyc=%0d", nmi_fall_cyc, w + 1); else n_pass++;
        n_checks++; if (int_n !== 1'b1) $display("FAIL nmi_int_idle got=%b exp=1", int_n); else n_pass++;
        base = nmi_lows;
        io_write(8'h93, 8'h04, 1, w, ia);
        @(posedge clk);
        io_write(8'h93, 8'h04, 1, w2, ia);
        repeat (12) @(posedge clk);
        @(negedge clk); #1;
        n_checks++; if (w2 !== w + 2) $display("FAIL nmi_retrig_pos got=%0d exp=%0d", w2, w + 2); else n_pass++;
        n_checks++; if (nmi_lows - base !== 6) $display("FAIL nmi_retrig_width got=%0d exp=6", nmi_lows - base); else n_pass++;
    endtask

    task automatic test_boundaries();
        int w, f, e, lows; bit ok; logic ia; logic [7:0] d;
        io_write(8'h90, 8'h00, 2, w, ia);
        io_write(8'h91, 8'h00, 2, w, ia);
        io_write(8'h93, 8'h01, 2, w, ia);
        io_read(8'h93, d);
        n_checks++; if (d !== 8'h01) $display("FAIL tmo0_ctrl got=%h exp=01", d); else n_pass++;
        lows = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (int_n !== 1'b1) lows++;
        end
        n_checks++; if (lows !== 0) $display("FAIL tmo0_no_int low_cycles=%0d exp=0", lows); else n_pass++;
        io_write(8'h93, 8'h00, 2, w, ia);
        io_write(8'h90, 8'hFF, 2, w, ia);
        io_write(8'h91, 8'hFF, 2, w, ia);
        io_write(8'h93, 8'h01, 2, w, ia);
        exp_q.push_back(w + 65535);
        wait_int_low(66000, f, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok) $display("FAIL tmo_max_fall timeout exp_cyc=%0d", e);
        else if (f !== e) $display("FAIL tmo_max_fall got_cyc=%0d exp_cyc=%0d", f, e);
        else n_pass++;
        @(negedge clk); #2 reset_n = 1'b0;
        #1;
        n_checks++; if (int_n !== 1'b1) $display("FAIL rst_pend_int got=%b exp=1", int_n); else n_pass++;
        bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
        #1;
        n_checks++; if (di !== zval) $display("FAIL rst_pend_di got=%h exp=%h", di, zval); else n_pass++;
        bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
        @(negedge clk) reset_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (int_n !== 1'b1) lows++;
        end
        n_checks++; if (lows !== 0) $display("FAIL rst_pend_stays low_cycles=%0d exp=0", lows); else n_pass++;
        io_read(8'h93, d);
        n_checks++; if (d !== 8'h00) $display("FAIL rst_pend_ctrl got=%h exp=00", d); else n_pass++;
    endtask

    initial begin
        zval = 8'hzz;
        test_reset();
        test_one_shot();
        test_reload();
        test_disable_pending();
        test_nmi();
        test_boundaries();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/env_int_gen.md
Name: env_int_gen

Overview:
- I/O-mapped interrupt generator for the tv80s simulation environment.
- Drives int_n/nmi_n into the CPU from a programmable cycle timer.
- Supplies the IM2 vector byte on the shared di bus during the interrupt-acknowledge cycle.
- Sits beside env_io on the same I/O strobes and lets test programs schedule their own interrupts.

Parameters:
BASE_ADDR, 8'h90, I/O address of register 0; the block decodes BASE_ADDR..BASE_ADDR+3.
NMI_PULSE, 4, number of clk cycles nmi_n is held low per NMI trigger (1..255).

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
m1_n  input  1  CPU M1 strobe.
iorq_n  input  1  CPU I/O request.
rd_n  input  1  CPU read strobe.
wr_n  input  1  CPU write strobe.
addr  input  8  CPU A[7:0].
DO  input  8  CPU write data.
DI  output  8  shared read bus; tri-state (8'hzz) when not selected.
int_n  output  1  maskable interrupt request, registered, active low.
nmi_n  output  1  non-maskable interrupt, registered, active low.

Behaviour:
- Register map:
  - BASE+0 TMO_LO: timeout bits 7:0.
  - BASE+1 TMO_HI: timeout bits 15:8.
  - BASE+2 VEC: IM2 vector.
  - BASE+3 CTRL, write: bit0 EN, bit1 RELOAD, bit2 NMI_GO (self-clearing, not stored).
  - CTRL read: {pending, 4'b0, 1'b0, RELOAD, EN}.
- Reset: all registers 0, state IDLE, int_n=1, nmi_n=1, DI=8'hzz, NMI counter 0.
- Write strobe: wsel = !iorq_n & !wr_n & m1_n & (addr matches). Only the first clk edge on which wsel is high (rising-edge detect, registered previous wsel) performs the write; the Z80 multi-cycle strobe yields exactly one write.
- Read: DI driven combinationally with the register when !iorq_n & !rd_n & m1_n & (addr matches).
- Ack: ack = !m1_n & !iorq_n. DI = VEC combinationally during ack whenever state==PEND; otherwise DI=8'hzz. The first edge of ack (edge detect) is the acknowledge event.
- Timer state machine, 16-bit down-counter cnt:
  - IDLE: a CTRL write with EN=1 and TMO!=0 loads cnt=TMO and goes to COUNT. EN=1 with TMO==0 stores EN but stays IDLE, so no interrupt.
  - COUNT: cnt decrements each clk. When cnt==1 and it decrements, go to PEND. int_n goes low exactly TMO clk edges after the enabling write edge.
  - PEND: int_n=0, pending=1. Held until the acknowledge event; int_n never self-clears.
    - On ack with RELOAD=1: cnt=TMO, go to COUNT, int_n=1 at the same edge.
    - On ack with RELOAD=0: EN cleared, go to IDLE, int_n=1.
  - Any state: a CTRL write with EN=0 goes to IDLE, int_n=1 and pending=0 at that edge.
- Writes to TMO during COUNT/PEND do not disturb cnt; the new value is used on the next load/reload.
- Simultaneous ack event and EN=0 write (impossible on a real bus, required anyway): the disable wins, IDLE.
- NMI:
  - A CTRL write with bit2=1 loads the NMI counter with NMI_PULSE. nmi_n=0 from the next edge while the counter is nonzero, decrementing each clk, so the pulse is exactly NMI_PULSE cycles low.
  - A retrigger during a pulse reloads the counter, extending the pulse.
  - NMI is independent of the timer state.
- Async reset mid-operation: immediately int_n=1, nmi_n=1, DI=z, IDLE; a pending interrupt is discarded.

Test Plan:
1. Reset checks: hold reset_n=0 → int_n=1, nmi_n=1, DI=8'hzz, and a CTRL read after reset returns 8'h00.
2. One-shot timer: write TMO_LO=8'h0A, TMO_HI=0, VEC=8'h40, CTRL=8'h01.
   - int_n falls exactly 10 clk after the CTRL write edge.
   - During the M1+IORQ ack, DI=8'h40.
   - After the ack, int_n=1 and a CTRL read returns 8'h00.
3. Auto-reload: TMO=3, CTRL=8'h03, with each interrupt acknowledged 2 cycles after int_n falls → int_n re-asserts 3 clk after each ack edge, for 4 consecutive periods.
4. Disable while pending: reach PEND, then write CTRL=0 with no ack → int_n returns to 1 at that write edge, and DI stays z on the next M1+IORQ cycle.
5. NMI pulse: write CTRL=8'h04 → nmi_n is low for exactly 4 cycles. A retrigger at pulse cycle 2 gives 6 total low cycles.
6. Boundaries:
   - TMO=0 with EN=1: no interrupt in 1000 cycles.
   - TMO=16'hFFFF: int_n falls at cycle 65535.
   - reset_n pulsed low during PEND: int_n=1 immediately and stays high.
